// File: rtl/eth_pkg.sv
// Shared 10BASE-T line coding types and timing constants.
// Used by the transmit PHY now and the receive side later.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    TPIDL,
    IPG
  } eth_state_t;

  localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;

  localparam int ETH_NLP_PERIOD     = 320000;
  localparam int ETH_NLP_WIDTH      = 2;
  localparam int ETH_TPIDL_CYCLES   = 5;
  localparam int ETH_IPG_CYCLES     = 192;
  localparam int ETH_PREAMBLE_BYTES = 7;

  // Half-bit h of byte b, LSB first: ~bit then bit.
  function automatic logic manch(
    input logic [7:0] b,
    input logic [3:0] h
  );
    return h[0] ? b[h[3:1]] : ~b[h[3:1]];
  endfunction

endpackage

// File: rtl/eth_nlp_gen.sv
// Normal link pulse generator: counts enabled idle cycles and
// emits a WIDTH-cycle pulse once PERIOD cycles have elapsed.
module eth_nlp_gen
  import eth_pkg::*;
#(
  parameter int PERIOD = ETH_NLP_PERIOD,
  parameter int WIDTH  = ETH_NLP_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic pulse
);

  localparam int PW = $clog2(PERIOD);
  localparam int WW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PW-1:0] cnt;
  logic [WW-1:0] wcnt;

  // A pulse in flight always runs to completion, even if en drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      wcnt  <= '0;
      pulse <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
    end else if (pulse) begin
      if (wcnt == WW'(WIDTH - 1)) begin
        pulse <= 1'b0;
        cnt   <= '0;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end else if (en) begin
      if (cnt == PW'(PERIOD - 1)) begin
        pulse <= 1'b1;
        wcnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_phy.sv
// 10BASE-T transmit line coder: preamble/SFD insertion,
// Manchester coding, TP_IDL, inter-packet gap and link pulses.
module eth_tx_phy
  import eth_pkg::*;
#(
  parameter int NLP_PERIOD     = ETH_NLP_PERIOD,
  parameter int NLP_WIDTH      = ETH_NLP_WIDTH,
  parameter int TPIDL_CYCLES   = ETH_TPIDL_CYCLES,
  parameter int IPG_CYCLES     = ETH_IPG_CYCLES,
  parameter int PREAMBLE_BYTES = ETH_PREAMBLE_BYTES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx_p,
  output logic       tx_n,
  output logic       tx_active,
  output logic       underrun
);

  localparam int CI = $clog2(IPG_CYCLES);
  localparam int CT = $clog2(TPIDL_CYCLES);
  localparam int CA = (CI > CT) ? CI : CT;
  localparam int CW = (CA > 4) ? CA : 4;
  localparam int PBW = (PREAMBLE_BYTES > 1) ?
                       $clog2(PREAMBLE_BYTES) : 1;

  eth_state_t     state;
  logic [CW-1:0]  cnt;
  logic [PBW-1:0] pcnt;
  logic [7:0]     sh;
  logic           fin;
  logic           lvl;
  logic           nlp;
  logic           byte_end;
  logic           restart;
  logic [3:0]     h_nxt;

  assign h_nxt    = cnt[3:0] + 4'd1;
  assign byte_end = (cnt == CW'(15));
  assign restart  = (state == TPIDL) &&
                    (cnt == CW'(TPIDL_CYCLES - 1));
  assign s_ready  = ((state == SFD) || (state == DATA)) &&
                    byte_end && !fin;

  // Frame start wins over an NLP due in the same cycle.
  eth_nlp_gen #(
    .PERIOD (NLP_PERIOD),
    .WIDTH  (NLP_WIDTH)
  ) u_nlp (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      ((state == IDLE) && !s_valid),
    .restart (restart),
    .pulse   (nlp)
  );

  assign tx_p = (tx_active & lvl) | nlp;
  assign tx_n = tx_active & ~lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pcnt      <= '0;
      sh        <= '0;
      fin       <= 1'b0;
      lvl       <= 1'b0;
      tx_active <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s_valid && !nlp) begin
            state     <= PRE;
            cnt       <= '0;
            pcnt      <= '0;
            sh        <= ETH_PREAMBLE_BYTE;
            fin       <= 1'b0;
            lvl       <= manch(ETH_PREAMBLE_BYTE, 4'd0);
            tx_active <= 1'b1;
          end
        end
        PRE: begin
          if (!byte_end) begin
            cnt <= cnt + 1'b1;
            lvl <= manch(sh, h_nxt);
          end else if (pcnt == PBW'(PREAMBLE_BYTES - 1)) begin
            cnt   <= '0;
            state <= SFD;
            sh    <= ETH_SFD_BYTE;
            lvl   <= manch(ETH_SFD_BYTE, 4'd0);
          end else begin
            cnt  <= '0;
            pcnt <= pcnt + 1'b1;
            lvl  <= manch(sh, 4'd0);
          end
        end
        SFD, DATA: begin
          if (!byte_end) begin
            cnt <= cnt + 1'b1;
            lvl <= manch(sh, h_nxt);
          end else if (s_ready && s_valid) begin
            state <= DATA;
            cnt   <= '0;
            sh    <= s_data;
            fin   <= s_last;
            lvl   <= manch(s_data, 4'd0);
          end else begin
            state    <= TPIDL;
            cnt      <= '0;
            lvl      <= 1'b1;
            underrun <= s_ready;
          end
        end
        TPIDL: begin
          if (restart) begin
            state     <= IPG;
            cnt       <= '0;
            lvl       <= 1'b0;
            tx_active <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IPG: begin
          // The IDLE cycle that follows is the last quiet cycle.
          if (cnt == CW'(IPG_CYCLES - 2)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_phy.sv
// Bench for eth_tx_phy: random frames against a per-cycle line
// model built from the 10BASE-T framing and link pulse rules.
module tb_eth_tx_phy;
  import eth_pkg::*;

  localparam int P   = 300;
  localparam int W   = 2;
  localparam int TPI = 5;
  localparam int IPC = 192;
  localparam int PB  = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       tx_p;
  logic       tx_n;
  logic       tx_active;
  logic       underrun;

  always #25 clk = ~clk;

  eth_tx_phy #(
    .NLP_PERIOD     (P),
    .NLP_WIDTH      (W),
    .TPIDL_CYCLES   (TPI),
    .IPG_CYCLES     (IPC),
    .PREAMBLE_BYTES (PB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .tx_p      (tx_p),
    .tx_n      (tx_n),
    .tx_active (tx_active),
    .underrun  (underrun)
  );

  int nvec = 0;
  int nerr = 0;

  // Stream entries: byte, +256 marks last, -1 withholds valid.
  int         sq[$];
  bit         go = 1'b0;
  // Expected {tx_p, tx_n, tx_active, s_ready, underrun}.
  logic [4:0] eq[$];
  bit         framing = 1'b0;
  bit         in_pulse = 1'b0;
  int         since = 0;
  int         pcount = 0;

  task automatic chk_eq(input string tag,
                        input logic [4:0] got,
                        input logic [4:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%b want=%b t=%0t",
               tag, got, want, $time);
    end
  endtask

  task automatic build_frame();
    logic [7:0] bl[$];
    bit und;
    int nd;
    int v;
    und = 1'b0;
    nd = 0;
    for (int i = 0; i < sq.size(); i++) begin
      v = sq[i];
      if (v < 0) begin
        und = 1'b1;
        break;
      end
      nd++;
      bl.push_back(v[7:0]);
      if (v >= 256) break;
    end
    eq.delete();
    for (int b = 0; b < PB + 1 + nd; b++) begin
      logic [7:0] cur;
      if (b < PB) cur = 8'h55;
      else if (b == PB) cur = 8'hD5;
      else cur = bl[b - PB - 1];
      for (int k = 0; k < 8; k++) begin
        logic r;
        r = (b >= PB) && (und || b < PB + nd) && (k == 7);
        eq.push_back({~cur[k], cur[k], 1'b1, 1'b0, 1'b0});
        eq.push_back({cur[k], ~cur[k], 1'b1, r, 1'b0});
      end
    end
    for (int t = 0; t < TPI; t++)
      eq.push_back({1'b1, 1'b0, 1'b1, 1'b0, und && t == 0});
    for (int t = 0; t < IPC; t++)
      eq.push_back(5'b0);
  endtask

  task automatic tick();
    logic hs;
    logic mk;
    logic sv;
    logic [4:0] e;
    int f;
    f = (sq.size() > 0) ? sq[0] : -1;
    s_valid = go && f >= 0;
    s_data  = (f >= 0) ? f[7:0] : 8'h00;
    s_last  = (f >= 0) ? f[8] : 1'b0;
    sv = s_valid;
    hs = s_valid && s_ready;
    mk = go && s_ready && sq.size() > 0 && f < 0;
    @(negedge clk);
    if (hs || mk) void'(sq.pop_front());
    if (framing && eq.size() == 0) begin
      framing = 1'b0;
      since = 0;
      in_pulse = 1'b0;
    end
    if (!framing) begin
      if (in_pulse) begin
        pcount++;
        if (pcount == W) begin
          in_pulse = 1'b0;
          since = 0;
        end
      end else if (sv) begin
        build_frame();
        framing = 1'b1;
      end else begin
        since++;
        if (since == P) begin
          in_pulse = 1'b1;
          pcount = 0;
        end
      end
    end
    e = framing ? eq.pop_front() : {in_pulse, 4'b0};
    chk_eq("line", {tx_p, tx_n, tx_active, s_ready, underrun}, e);
  endtask

  task automatic run_until_idle();
    int k;
    k = 0;
    while ((framing || sq.size() > 0) && k < 6000) begin
      tick();
      k++;
    end
    chk_eq("drain", {4'b0, k < 6000}, 5'd1);
  endtask

  task automatic push_frame(input int n, input int drop);
    for (int i = 0; i < n; i++) begin
      if (i == drop) begin
        sq.push_back(-1);
        break;
      end
      sq.push_back(int'($urandom_range(0, 255)) +
                   ((i == n - 1) ? 256 : 0));
    end
  endtask

  initial begin
    int k;
    int n;
    repeat (3) @(negedge clk);
    chk_eq("reset", {tx_p, tx_n, tx_active, s_ready, underrun},
           5'b0);
    rst_n = 1'b1;
    go = 1'b1;
    repeat (2 * P + 10) tick();

    sq.push_back(256 + 8'hA5);
    run_until_idle();
    repeat (5) tick();

    sq.push_back(8'h01);
    sq.push_back(8'h02);
    sq.push_back(256 + 8'h03);
    run_until_idle();

    push_frame(3, 1);
    run_until_idle();

    push_frame(2, 9);
    push_frame(4, 9);
    run_until_idle();

    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 6);
      if (n > 1 && $urandom_range(0, 3) == 0)
        push_frame(n, $urandom_range(1, n - 1));
      else
        push_frame(n, 9);
      if ($urandom_range(0, 1) == 1)
        push_frame($urandom_range(1, 4), 9);
      run_until_idle();
      repeat ($urandom_range(0, 50)) tick();
    end

    k = 0;
    while (!(since == P - 1 && !in_pulse) && k < 3 * P) begin
      tick();
      k++;
    end
    chk_eq("due_wait", {4'b0, k < 3 * P}, 5'd1);
    push_frame(2, 9);
    run_until_idle();
    repeat (P + 10) tick();

    k = 0;
    while (!(in_pulse && pcount == 0) && k < 3 * P) begin
      tick();
      k++;
    end
    chk_eq("nlp_wait", {4'b0, k < 3 * P}, 5'd1);
    push_frame(1, 9);
    run_until_idle();
    repeat (P + 10) tick();

    push_frame(4, 9);
    repeat (60) tick();
    rst_n = 1'b0;
    #1;
    chk_eq("async_rst",
           {tx_p, tx_n, tx_active, s_ready, underrun}, 5'b0);
    sq.delete();
    eq.delete();
    framing = 1'b0;
    in_pulse = 1'b0;
    since = 0;
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (P + 10) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
